// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle sequencer for the mini-MIPS core. Each instruction is stepped
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). EXEC is stretched for
// integer multiply and FP arithmetic. Retired instructions are counted.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, halt_req      run control (start from IDLE/HALT, halt after retire)
//   reg_write .. mtc1    decoder control bits, sampled in DECODE
//   alu_op, jump_src     decoder ALU op / jump source (10 = register)
//   branch_taken         branch comparator result, used live in EXEC
//   imem_req/imem_ready  instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data access handshake
//   ir_write, pc_write, pc_sel   IR/PC update controls
//   gpr_we, fpr_we       integer / FP register file write enables
//   state, busy          current state encoding and running indicator
//   instr_count          retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned FP_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_float,
  input  logic        mfc1,
  input  logic        mtc1,
  input  logic [3:0]  alu_op,
  input  logic [1:0]  jump_src,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        gpr_we,
  output logic        fpr_we,
  output logic [2:0]  state,
  output logic        busy,
  output logic [31:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halt_pending_q, halt_pending_d;
  logic [31:0] instr_count_q;

  // Decoder controls captured in DECODE and held for the rest of the instruction
  logic        rw_q, mr_q, mw_q, br_q, jmp_q, flt_q, mfc1_q, mtc1_q;
  logic [1:0]  jsrc_q;

  logic        instr_end;
  logic        busy_w;
  logic        mul_op, fp_op;
  logic [3:0]  exec_len;

  // alu_op only decides the EXEC length, so it is consumed here in DECODE
  // and never latched.
  always_comb begin
    mul_op   = ~is_float & ((alu_op == 4'b0011) | (alu_op == 4'b0100) |
                            (alu_op == 4'b0101));
    fp_op    = is_float & reg_write & ~mfc1;
    exec_len = mul_op ? 4'(MUL_CYCLES) : (fp_op ? 4'(FP_CYCLES) : 4'd1);
  end

  assign busy_w = (state_q != S_IDLE) && (state_q != S_HALT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_SEQ;
    gpr_we    = 1'b0;
    fpr_we    = 1'b0;
    instr_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        cnt_d   = exec_len;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // A count of 0 can only come from an out-of-range parameter; treat it
        // like 1 so EXEC can never lock up.
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (jmp_q) begin
            if (rw_q) begin
              state_d = S_WB;          // jal: PC written in WB with the link
            end else begin
              pc_write  = 1'b1;
              pc_sel    = (jsrc_q == 2'b10) ? PC_REG : PC_JMP;
              instr_end = 1'b1;
            end
          end else if (br_q) begin
            pc_write  = 1'b1;
            pc_sel    = branch_taken ? PC_BR : PC_SEQ;
            instr_end = 1'b1;
          end else if (mr_q | mw_q) begin
            state_d = S_MEM;
          end else if (rw_q | mtc1_q) begin
            state_d = S_WB;
          end else begin
            pc_write  = 1'b1;            // compares and undefined encodings
            pc_sel    = PC_SEQ;
            instr_end = 1'b1;
          end
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw_q;
        if (dmem_ready) begin
          if (mr_q) begin
            state_d = S_WB;
          end else begin
            pc_write  = 1'b1;
            pc_sel    = PC_SEQ;
            instr_end = 1'b1;
          end
        end
      end

      S_WB: begin
        // mtc1 targets the FPR file only; masking it out of gpr_we keeps the
        // two write enables exclusive even for malformed decoder output.
        gpr_we    = rw_q & ~(flt_q & ~mfc1_q) & ~mtc1_q;
        fpr_we    = (flt_q & rw_q & ~mfc1_q) | mtc1_q;
        pc_write  = 1'b1;
        pc_sel    = (jmp_q & rw_q) ? PC_JMP : PC_SEQ;
        instr_end = 1'b1;
      end

      S_HALT: begin
        if (start) state_d = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;                // unused encoding 7
      end
    endcase

    if (instr_end) begin
      state_d = (halt_pending_q | halt_req) ? S_HALT : S_FETCH;
    end

    halt_pending_d = halt_pending_q;
    if (busy_w && halt_req) halt_pending_d = 1'b1;
    if (state_d == S_HALT)  halt_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      halt_pending_q <= 1'b0;
      instr_count_q  <= 32'd0;
      rw_q           <= 1'b0;
      mr_q           <= 1'b0;
      mw_q           <= 1'b0;
      br_q           <= 1'b0;
      jmp_q          <= 1'b0;
      flt_q          <= 1'b0;
      mfc1_q         <= 1'b0;
      mtc1_q         <= 1'b0;
      jsrc_q         <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      halt_pending_q <= halt_pending_d;
      if (instr_end) instr_count_q <= instr_count_q + 32'd1;
      if (state_q == S_DECODE) begin
        rw_q   <= reg_write;
        mr_q   <= mem_read;
        mw_q   <= mem_write;
        br_q   <= branch;
        jmp_q  <= jump;
        flt_q  <= is_float;
        mfc1_q <= mfc1;
        mtc1_q <= mtc1;
        jsrc_q <= jump_src;
      end
    end
  end

  assign state       = state_q;
  assign busy        = busy_w;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Scoreboard bench: for each instruction a per-cycle expected output trace is
// built from the decoder bits and memory wait states. Each cycle's expectation
// is pushed when that cycle's stimulus is driven and popped/compared on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int MUL_CYCLES = 4;
  localparam int FP_CYCLES  = 3;

  logic        clk, rst, start, halt_req;
  logic        reg_write, mem_read, mem_write, branch, jump, is_float, mfc1, mtc1;
  logic [3:0]  alu_op;
  logic [1:0]  jump_src;
  logic        branch_taken;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        ir_write, pc_write, gpr_we, fpr_we, busy;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] instr_count;

  multicycle_control_fsm #(.MUL_CYCLES(MUL_CYCLES), .FP_CYCLES(FP_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .is_float(is_float), .mfc1(mfc1), .mtc1(mtc1),
    .alu_op(alu_op), .jump_src(jump_src), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .gpr_we(gpr_we), .fpr_we(fpr_we), .state(state), .busy(busy),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rw, mr, mw, br, j, f, mfc1, mtc1;
    logic [3:0] alu;
    logic [1:0] js;
    logic       bt;
  } ctrl_t;

  typedef struct {
    logic        imr, dmr, halt;
    logic [12:0] exp;
  } cyc_t;

  typedef struct {
    string       nm;
    logic [12:0] v;
  } sb_t;

  cyc_t  tr[$];
  sb_t   sb_q[$];
  sb_t   mon_e;
  int    n_total = 0;
  int    n_bad   = 0;
  int    exp_count = 0;

  logic [12:0] obs;
  assign obs = {state, busy, imem_req, ir_write, dmem_req, dmem_we,
                pc_write, pc_sel, gpr_we, fpr_we};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Output word layout: {state, busy, imem_req, ir_write, dmem_req, dmem_we,
  //                      pc_write, pc_sel, gpr_we, fpr_we}
  function automatic logic [12:0] mk(input logic [2:0] st, input logic imr, input logic ir,
                                     input logic dr, input logic dwe, input logic pw,
                                     input logic [1:0] ps, input logic g, input logic fw);
    logic bz;
    bz = (st != 3'd0) && (st != 3'd6);
    return {st, bz, imr, ir, dr, dwe, pw, ps, g, fw};
  endfunction

  function automatic ctrl_t mkc(input logic rw, input logic mr, input logic mw, input logic br,
                                input logic j, input logic f, input logic m_fc1, input logic m_tc1,
                                input logic [3:0] alu, input logic [1:0] js, input logic bt);
    ctrl_t c;
    c.rw = rw; c.mr = mr; c.mw = mw; c.br = br; c.j = j; c.f = f;
    c.mfc1 = m_fc1; c.mtc1 = m_tc1; c.alu = alu; c.js = js; c.bt = bt;
    return c;
  endfunction

  task automatic push_cyc(input logic [12:0] e, input logic imr, input logic dmr, input logic h);
    cyc_t r;
    r.exp = e; r.imr = imr; r.dmr = dmr; r.halt = h;
    tr.push_back(r);
  endtask

  // Expected trace of one instruction. iw/dw = wait cycles before imem/dmem
  // ready, hx = EXEC cycle index carrying a halt_req pulse (-1 for none).
  task automatic build(input ctrl_t c, input int iw, input int dw, input int hx);
    int         elen;
    logic       mul_op, fp_op, to_mem, to_wb, pw;
    logic [1:0] ps;
    logic       g, fw;
    mul_op = !c.f && (c.alu == 4'b0011 || c.alu == 4'b0100 || c.alu == 4'b0101);
    fp_op  = c.f && c.rw && !c.mfc1;
    elen   = mul_op ? MUL_CYCLES : (fp_op ? FP_CYCLES : 1);
    for (int i = 0; i <= iw; i++)
      push_cyc(mk(3'd1, 1, (i == iw), 0, 0, 0, 2'b00, 0, 0), (i == iw), 1'($urandom), 0);
    push_cyc(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1, 1'($urandom), 0);
    to_mem = 0; to_wb = 0; pw = 0; ps = 2'b00;
    if (c.j) begin
      if (c.rw) to_wb = 1;
      else begin pw = 1; ps = (c.js == 2'b10) ? 2'b11 : 2'b10; end
    end else if (c.br) begin
      pw = 1; ps = c.bt ? 2'b01 : 2'b00;
    end else if (c.mr || c.mw) to_mem = 1;
    else if (c.rw || c.mtc1) to_wb = 1;
    else pw = 1;
    for (int i = 0; i < elen; i++) begin
      if (i < elen - 1)
        push_cyc(mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1, 1'($urandom), (i == hx));
      else
        push_cyc(mk(3'd3, 0, 0, 0, 0, pw, ps, 0, 0), 1, 1'($urandom), (i == hx));
    end
    if (to_mem) begin
      for (int i = 0; i <= dw; i++)
        push_cyc(mk(3'd4, 0, 0, 1, c.mw, (i == dw) && !c.mr, 2'b00, 0, 0), 1, (i == dw), 0);
      if (c.mr) to_wb = 1;
    end
    if (to_wb) begin
      g  = c.rw & ~(c.f & ~c.mfc1);
      fw = (c.f & c.rw & ~c.mfc1) | c.mtc1;
      push_cyc(mk(3'd5, 0, 0, 0, 0, 1, (c.j && c.rw) ? 2'b10 : 2'b00, g, fw), 1, 1'($urandom), 0);
    end
  endtask

  task automatic apply_ctrl(input ctrl_t c);
    reg_write = c.rw; mem_read = c.mr; mem_write = c.mw; branch = c.br;
    jump = c.j; is_float = c.f; mfc1 = c.mfc1; mtc1 = c.mtc1;
    alu_op = c.alu; jump_src = c.js; branch_taken = c.bt;
  endtask

  // After DECODE the decoder bits are junk; only branch_taken stays valid.
  task automatic scramble();
    reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    branch = 1'($urandom); jump = 1'($urandom); is_float = 1'($urandom);
    mfc1 = 1'($urandom); mtc1 = 1'($urandom); alu_op = 4'($urandom);
    jump_src = 2'($urandom);
  endtask

  // Called one cycle before the DUT enters FETCH; drives up to max_cyc cycles.
  task automatic run_instr(input string nm, input ctrl_t c, input int iw, input int dw,
                           input int hx, input int max_cyc);
    sb_t e;
    tr.delete();
    build(c, iw, dw, hx);
    for (int k = 0; k < tr.size() && k < max_cyc; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0;
        chk({nm, "/count"}, instr_count, exp_count);
        apply_ctrl(c);
      end
      if (tr[k].exp[12:10] >= 3'd3) scramble();
      imem_ready = tr[k].imr;
      dmem_ready = tr[k].dmr;
      halt_req   = tr[k].halt;
      e.nm = $sformatf("%s/cyc%0d", nm, k);
      e.v  = tr[k].exp;
      sb_q.push_back(e);
    end
    if (max_cyc >= tr.size()) exp_count++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.nm, {19'd0, obs}, {19'd0, mon_e.v});
    end
  end

  initial begin
    ctrl_t c_add, c_lw, c_sw, c_mul, c_madd, c_adds, c_beq_t, c_beq_n;
    ctrl_t c_jr, c_j, c_jal, c_mtc1, c_mfc1, c_nop;
    c_add   = mkc(1,0,0,0,0,0,0,0, 4'b0001, 2'b00, 0);
    c_lw    = mkc(1,1,0,0,0,0,0,0, 4'b0001, 2'b00, 0);
    c_sw    = mkc(0,0,1,0,0,0,0,0, 4'b0001, 2'b00, 0);
    c_mul   = mkc(1,0,0,0,0,0,0,0, 4'b0101, 2'b00, 0);
    c_madd  = mkc(0,0,0,0,0,0,0,0, 4'b0011, 2'b00, 0);
    c_adds  = mkc(1,0,0,0,0,1,0,0, 4'b0001, 2'b00, 0);
    c_beq_t = mkc(0,0,0,1,0,0,0,0, 4'b0110, 2'b00, 1);
    c_beq_n = mkc(0,0,0,1,0,0,0,0, 4'b0110, 2'b00, 0);
    c_jr    = mkc(0,0,0,0,1,0,0,0, 4'b0000, 2'b10, 0);
    c_j     = mkc(0,0,0,0,1,0,0,0, 4'b0000, 2'b01, 0);
    c_jal   = mkc(1,0,0,0,1,0,0,0, 4'b0000, 2'b01, 0);
    c_mtc1  = mkc(0,0,0,0,0,1,0,1, 4'b0000, 2'b00, 0);
    c_mfc1  = mkc(1,0,0,0,0,1,1,0, 4'b0000, 2'b00, 0);
    c_nop   = mkc(0,0,0,0,0,0,0,0, 4'b1111, 2'b00, 0);

    start = 0; halt_req = 0; imem_ready = 1; dmem_ready = 0;
    apply_ctrl(c_nop);
    rst = 0;
    #1 rst = 1;
    #2;
    chk("reset_outputs", {19'd0, obs}, 32'd0);
    chk("reset_count", instr_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    start = 1;                       // halt_req in IDLE must be ignored
    halt_req = 1;
    @(posedge clk); #1;
    halt_req = 0;
    chk("idle_start", {29'd0, state}, 32'd1);
    // DUT is now in FETCH; re-align by restarting from HALT-free FETCH path:
    // hold start low and let this FETCH run as the add below.
    tr.delete();
    build(c_add, 0, 0, -1);
    apply_ctrl(c_add);
    start = 0;
    for (int k = 0; k < tr.size(); k++) begin
      sb_t e;
      if (k > 0) begin @(posedge clk); #1; end
      if (tr[k].exp[12:10] >= 3'd3) scramble();
      imem_ready = tr[k].imr;
      dmem_ready = tr[k].dmr;
      e.nm = $sformatf("add/cyc%0d", k);
      e.v  = tr[k].exp;
      sb_q.push_back(e);
    end
    exp_count++;

    run_instr("lw_wait3", c_lw,    0, 3, -1, 99);
    run_instr("sw_iw2",   c_sw,    2, 0, -1, 99);
    run_instr("mul",      c_mul,   0, 0, -1, 99);
    run_instr("madd",     c_madd,  1, 0, -1, 99);
    run_instr("add_s",    c_adds,  0, 0, -1, 99);
    run_instr("beq_t",    c_beq_t, 0, 0, -1, 99);
    run_instr("beq_n",    c_beq_n, 0, 0, -1, 99);
    run_instr("jr",       c_jr,    0, 0, -1, 99);
    run_instr("j",        c_j,     0, 0, -1, 99);
    run_instr("jal",      c_jal,   0, 0, -1, 99);
    run_instr("mtc1",     c_mtc1,  0, 0, -1, 99);
    run_instr("mfc1",     c_mfc1,  0, 0, -1, 99);
    run_instr("nop",      c_nop,   0, 0, -1, 99);
    run_instr("lw_wait0", c_lw,    0, 0, -1, 99);

    // halt_req on the 2nd EXEC cycle of mul: retire, then park in HALT
    run_instr("mul_halt", c_mul,   0, 0, 1, 99);
    @(posedge clk); #1;
    chk("halt_state", {19'd0, obs}, {19'd0, mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    chk("halt_count", instr_count, exp_count);
    imem_ready = 1; dmem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("halt_hold", {19'd0, obs}, {19'd0, mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    start = 1;
    run_instr("add_after_halt", c_add, 0, 0, -1, 99);
    run_instr("sw_after_halt",  c_sw,  0, 0, -1, 99);

    // Asynchronous reset in the middle of a stalled load (2nd MEM cycle)
    run_instr("lw_rst", c_lw, 0, 5, -1, 5);
    @(negedge clk);
    #2;
    chk("pre_rst_dmem_req", {31'd0, dmem_req}, 32'd1);
    rst = 1;
    #1;
    exp_count = 0;
    chk("rst_outputs", {19'd0, obs}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    dmem_ready = 1;                  // stale ready after release: ignored
    @(posedge clk); #1;
    dmem_ready = 0;
    chk("post_rst_idle", {19'd0, obs}, 32'd0);
    start = 1;
    run_instr("add_after_rst", c_add, 0, 0, -1, 99);
    @(posedge clk); #1;
    chk("final_count", instr_count, exp_count);
    chk("final_state", {29'd0, state}, 32'd1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
